// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: default line settings, receive states and the 3-sample majority vote.
package uart_pkg;
  localparam int CLK_FREQ_DEF = 10_000_000;
  localparam int BAUD_DEF     = 115_200;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PARITY, STOP} rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// Consumer-side port bundle of the UART receiver: show-ahead FIFO head, pop strobe and fill level.
interface uart_rx_if #(parameter int FIFO_DEPTH = 4);
  import uart_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 rd_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic [CW-1:0]        fifo_count;

  modport master (input rd_en, output rx_data, rx_valid, fifo_count);
  modport slave  (output rd_en, input rx_data, rx_valid, fifo_count);
endinterface

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Show-ahead FIFO for received bytes; head is visible on dout whenever not empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign do_rd = rd_en & ~empty;
  // a full FIFO still accepts a write when the same edge frees a slot
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_rd) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end
endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 oversampling UART receiver with majority-vote sampling and a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to require an even-parity bit between data and stop.
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  uart_rx_if.master rx_if,
  output logic      rx_busy,
  output logic      rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic      rx_parity_err,
`endif
  output logic      rx_overrun
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_LO   = SW'(M - 1);
  localparam logic [SW-1:0] S_MID  = SW'(M);
  localparam logic [SW-1:0] S_HI   = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);
  localparam logic [31:0]   INC  = 32'(BAUD * OVERSAMPLE);
  localparam logic [31:0]   CLKF = 32'(CLK_FREQ);

  logic                 rxd_s1, rxd_s;
  logic [31:0]          acc, acc_sum;
  logic                 tick;
  rx_state_e            state, state_nxt;
  logic [SW-1:0]        scnt, scnt_nxt;
  logic [2:0]           idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 smp_lo, smp_mid, maj;
  logic                 push, ferr, ovr;
  logic                 fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nxt, perr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s  <= rxd_s1;
    end
  end

  // free-running fractional divider, never realigned to frames
  assign acc_sum = acc + INC;
  assign tick    = (acc_sum >= CLKF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= tick ? acc_sum - CLKF : acc_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_lo  <= 1'b1;
      smp_mid <= 1'b1;
    end else if (tick) begin
      if (scnt == S_LO)  smp_lo  <= rxd_s;
      if (scnt == S_MID) smp_mid <= rxd_s;
    end
  end

  assign maj = maj3(smp_lo, smp_mid, rxd_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_HIGH;
      scnt  <= '0;
      idx   <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    push      = 1'b0;
    ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
    perr      = 1'b0;
`endif
    if (tick) begin
      scnt_nxt = (scnt == S_LAST) ? '0 : scnt + 1'b1;
      case (state)
        WAIT_HIGH: if (rxd_s) state_nxt = IDLE;
        IDLE: begin
          scnt_nxt = '0;
          if (!rxd_s) state_nxt = START;
        end
        START: begin
          if (scnt == S_HI && maj) state_nxt = IDLE;
          else if (scnt == S_LAST) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end
        end
        DATA: begin
          if (scnt == S_HI) shreg_nxt[idx] = maj;
          if (scnt == S_LAST) begin
            idx_nxt = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx == IDX_LAST) state_nxt = PARITY;
`else
            if (idx == IDX_LAST) state_nxt = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (scnt == S_HI)   par_nxt   = maj;
          if (scnt == S_LAST) state_nxt = STOP;
        end
`endif
        // decide at mid stop bit so a back-to-back start edge is not missed
        STOP: begin
          if (scnt == S_HI) begin
            state_nxt = IDLE;
            if (!maj) begin
              ferr      = 1'b1;
              state_nxt = WAIT_HIGH;
            end
`ifdef UART_RX_PARITY_EN
            else if (^{shreg, par_bit}) perr = 1'b1;
`endif
            else push = 1'b1;
          end
        end
        default: state_nxt = WAIT_HIGH;
      endcase
    end
  end

  uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (push),
    .rd_en (rx_if.rd_en),
    .din   (shreg),
    .dout  (rx_if.rx_data),
    .count (rx_if.fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_if.rx_valid = ~fifo_empty;
  assign rx_busy        = (state != IDLE) && (state != WAIT_HIGH);
  assign ovr            = push & fifo_full & ~(rx_if.rd_en & ~fifo_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err  <= ferr;
      rx_overrun    <= ovr;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= perr;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: drives serial frames, scoreboards received bytes, counts flag pulses.
// Build with UART_RX_PARITY_EN to cover the parity variant.
module tb_uart_rx;
  localparam int  CLKF   = 10_000_000;
  localparam int  BAUDR  = 115_200;
  localparam int  OVS    = 16;
  localparam real BIT_NS = 1.0e9 / BAUDR;
`ifdef UART_RX_PARITY_EN
  localparam int  FRAME_BITS = 11;
`else
  localparam int  FRAME_BITS = 10;
`endif
  // ticks from the start-detect edge to the mid-stop decision edge
  localparam int  PUSH_TICKS = (FRAME_BITS - 1) * OVS + OVS / 2 + 2;

  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
  logic rx_busy, rx_frame_err, rx_overrun, busy_seen;
`ifdef UART_RX_PARITY_EN
  logic rx_parity_err;
  logic par_flip = 1'b0;
  int   n_perr = 0;
`endif
  int         n_chk = 0, n_err = 0, n_ferr = 0, n_ovr = 0;
  longint     edge_n;
  logic [7:0] exp_q[$];

  uart_rx_if #(.FIFO_DEPTH(4)) rif ();

  uart_rx #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .OVERSAMPLE(OVS), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .rx_if        (rif),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_overrun   (rx_overrun)
  );

  always #50 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (rx_frame_err) n_ferr <= n_ferr + 1;
    if (rx_overrun)   n_ovr  <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) n_perr <= n_perr + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // tick fires on edge n when n*INC crosses a multiple of CLKF
  function automatic bit tick_at(input longint n);
    longint inc = longint'(BAUDR) * OVS;
    return ((n * inc) / CLKF) != (((n - 1) * inc) / CLKF);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    rxd = 1'b0; #(BIT_NS);
    for (int i = 0; i < 8; i++) begin rxd = d[i]; #(BIT_NS); end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip; #(BIT_NS);
`endif
    rxd = stop_b; #(BIT_NS);
  endtask

  task automatic pop_chk(input string tag);
    int w = 0;
    logic [7:0] e;
    @(negedge clk);
    while (!rif.rx_valid && w < 4000) begin @(negedge clk); w++; end
    chk({tag, "_vld"}, {31'd0, rif.rx_valid}, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk({tag, "_dat"}, {24'd0, rif.rx_data}, {24'd0, e});
    rif.rd_en = 1'b1;
    @(negedge clk);
    rif.rd_en = 1'b0;
  endtask

  // raise rd_en for exactly the edge on which the next frame is pushed
  task automatic pop_at_push();
    longint e;
    int k = 0, w = 0;
    @(negedge clk);
    while (!rx_busy && w < 4000) begin @(negedge clk); w++; end
    chk("simul_det", {31'd0, rx_busy}, 1);
    e = edge_n;
    while (k < PUSH_TICKS) begin e++; if (tick_at(e)) k++; end
    while (edge_n < e - 1) @(negedge clk);
    chk("simul_full", {29'd0, rif.fifo_count}, 4);
    rif.rd_en = 1'b1;
    chk("simul_pop", {24'd0, rif.rx_data}, {24'd0, exp_q.pop_front()});
    @(negedge clk);
    rif.rd_en = 1'b0;
  endtask

  initial begin
    rif.rd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_vld", {31'd0, rif.rx_valid}, 0);
    chk("rst_cnt", {29'd0, rif.fifo_count}, 0);
    chk("rst_busy", {31'd0, rx_busy}, 0);
    chk("rst_flags", {30'd0, rx_frame_err, rx_overrun}, 0);
    rst_n = 1'b1;
    #(2 * BIT_NS);

    // basic byte and its latency window
    fork
      send_frame(8'h55, 1'b1);
      begin #(9 * BIT_NS); @(negedge clk); chk("lat_early", {31'd0, rif.rx_valid}, 0); end
    join
    exp_q.push_back(8'h55);
    @(negedge clk);
    chk("lat_late", {31'd0, rif.rx_valid}, 1);
    pop_chk("b55");
    chk("pop_vld", {31'd0, rif.rx_valid}, 0);
    chk("pop_cnt", {29'd0, rif.fifo_count}, 0);

    // short low glitch is a false start
    rxd = 1'b0; #2000; rxd = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    chk("glitch_cnt", {29'd0, rif.fifo_count}, 0);
    chk("glitch_flags", n_ferr + n_ovr, 0);
    chk("glitch_busy", {31'd0, rx_busy}, 0);
    send_frame(8'hA3, 1'b1); exp_q.push_back(8'hA3);
    pop_chk("bA3");

    // bad stop bit, line stuck low, then recovery
    send_frame(8'hA5, 1'b0);
    #(3 * BIT_NS); rxd = 1'b1; #(BIT_NS);
    send_frame(8'h3C, 1'b1); exp_q.push_back(8'h3C);
    @(negedge clk);
    chk("ferr_cnt", n_ferr, 1);
    chk("ferr_fifo", {29'd0, rif.fifo_count}, 1);
    pop_chk("b3C");

    // five back-to-back frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i < 5) exp_q.push_back(8'(i));
    end
    @(negedge clk);
    chk("ovr_cnt", {29'd0, rif.fifo_count}, 4);
    chk("ovr_pulse", n_ovr, 1);
    for (int i = 0; i < 4; i++) pop_chk("ovr_q");
    chk("ovr_drain", {29'd0, rif.fifo_count}, 0);

    // same again, popping on the push edge of the fifth frame
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(8'h10 + i), 1'b1);
      exp_q.push_back(8'(8'h10 + i));
    end
    exp_q.push_back(8'h15);
    fork
      send_frame(8'h15, 1'b1);
      pop_at_push();
    join
    @(negedge clk);
    chk("simul_ovr", n_ovr, 1);
    chk("simul_cnt", {29'd0, rif.fifo_count}, 4);
    for (int i = 0; i < 4; i++) pop_chk("simul_q");

    // reset in the middle of 0xFF data, line held low afterwards
    send_frame(8'h99, 1'b1);
    @(negedge clk);
    chk("pre_rst_cnt", {29'd0, rif.fifo_count}, 1);
    rxd = 1'b0; #(BIT_NS); rxd = 1'b1; #(2 * BIT_NS);
    @(negedge clk);
    chk("mid_busy", {31'd0, rx_busy}, 1);
    rst_n = 1'b0; rxd = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (174) begin @(negedge clk); busy_seen = busy_seen | rx_busy; end
    chk("rst_cnt2", {29'd0, rif.fifo_count}, 0);
    chk("rst_vld2", {31'd0, rif.rx_valid}, 0);
    chk("rst_nostart", {31'd0, busy_seen}, 0);
    rxd = 1'b1; #(2 * BIT_NS);
    send_frame(8'h7E, 1'b1); exp_q.push_back(8'h7E);
    pop_chk("b7E");

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1); exp_q.push_back(8'h07);
    pop_chk("par_ok");
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    #(BIT_NS); @(negedge clk);
    chk("par_err", n_perr, 1);
    chk("par_nopush", {29'd0, rif.fifo_count}, 0);
`endif

    chk("q_empty", exp_q.size(), 0);
    chk("final_ferr", n_ferr, 1);
    chk("final_ovr", n_ovr, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1, LSB first; the receive-side counterpart of the board's UART transmitter path.
- Oversamples the incoming line, validates the start bit, checks the stop bit and queues good bytes in a small show-ahead FIFO.
- Sits between a connector GPIO input pin and on-chip consumers, for example a command parser or a 1-Wire control FSM.
- Runs on the single 10 MHz board clock.

Parameters:
- CLK_FREQ, 10000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- rxd  in  1  serial line input; asynchronous; idle level is high.
- rd_en  in  1  pop the FIFO head; ignored when rx_valid is 0.
- rx_data  out  8  FIFO head byte; valid only while rx_valid is 1.
- rx_valid  out  1  FIFO is not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes in the FIFO.
- rx_busy  out  1  a frame is in progress (state is not IDLE and not WAIT_HIGH).
- rx_frame_err  out  1  one-cycle pulse when the stop bit samples low.
- rx_overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty.
  - Synchroniser flops preset to 1.
  - State resets to WAIT_HIGH.
- Input synchronisation: rxd passes through a 2-flop synchroniser. All decisions use the synchronised signal, which adds 2 cycles of latency.
- Tick generator:
  - Fractional accumulator: add BAUD*OVERSAMPLE every clk.
  - When the sum is >= CLK_FREQ, subtract CLK_FREQ and assert tick for one cycle.
  - The average tick rate is exact. The accumulator runs freely and is never reset by frame events.
- Sample counter scnt (0..OVERSAMPLE-1) advances on tick only.
- Midpoint M = OVERSAMPLE/2. Bit value = majority of the samples taken at scnt M-1, M and M+1.
- State machine (all transitions occur on tick):
  - WAIT_HIGH: leave for IDLE when the synchronised line is 1 at a tick.
  - IDLE: synchronised line 0 at a tick -> scnt=0, go to START.
  - START: at scnt=M+1, majority 1 -> false start, go to IDLE with no flags. Majority 0 -> continue. At scnt wrap, go to DATA with bit index 0.
  - DATA: at scnt=M+1, shift the majority value into bit[idx]. At scnt wrap, idx++. After idx 7 completes, go to STOP.
  - STOP: at scnt=M+1 the frame decision is made.
    - Majority 1: push the byte and go to IDLE immediately, at mid stop bit, so back-to-back frames are caught.
    - Majority 0: pulse rx_frame_err, discard the byte, go to WAIT_HIGH.
- FIFO rules:
  - Push and pop take effect on the same edge.
  - rx_valid rises 1 cycle after the push.
  - Full with push and no pop: the new byte is dropped and rx_overrun pulses; stored bytes are unchanged.
  - Full with push and pop in the same cycle: both succeed, no overrun.
  - Empty with rd_en: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: the partial byte is lost, the FIFO is cleared, and the receiver resynchronises only after the line has been seen high.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; the parity bit is sampled by majority vote.
  - Even parity is required: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, the byte is discarded and port rx_parity_err (out, 1) pulses for one cycle at the STOP decision.
  - A frame error takes precedence: if both errors occur, only rx_frame_err pulses.
- Undefined: the PARITY state and the rx_parity_err port are absent, and the frame format is 8N1.

Decomposition:
- Package uart_pkg:
  - Receive state enum: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP.
  - DATA_BITS=8.
  - A maj3 function.
  - Default CLK_FREQ and BAUD constants, shared with the transmitter.
- Sub-module uart_rx_fifo (parameterised by WIDTH and DEPTH) holding the show-ahead FIFO. The receive FSM and tick generator stay in uart_rx.

Test Plan:
- Reset, line idle high, send 0x55 at 115200 -> rx_valid=1 and rx_data=0x55 about 9.5 bit times after the start edge; pulse rd_en -> rx_valid=0, fifo_count=0.
- 2 µs low glitch on an idle line (less than half a bit, about 4.3 µs) -> no push, no flags; a following 0xA3 frame is received correctly.
- Frame 0xA5 with stop bit forced low, line then held low for 3 bit times and released, then 0x3C -> one rx_frame_err pulse, FIFO holds only 0x3C.
- Five back-to-back frames 0x01..0x05 with no reads, FIFO_DEPTH=4 -> fifo_count=4 holding 0x01..0x04, one rx_overrun pulse on 0x05; repeat with rd_en asserted on the push cycle -> no overrun.
- Reset asserted mid-DATA of 0xFF, released with the line low for 2 bit times -> no start until the line goes high; the next 0x7E is received cleanly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> accepted; 0x07 with parity bit 0 -> rx_parity_err pulse, no push.
